// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU MEM stage and a DMA port.
// Round-robin ownership with a per-owner burst limit; build with
// DMEM_ARB_CPU_PRIO_EN to make the CPU win all ties and never be preempted.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cpu_req/we/addr/wd   CPU request + payload (held until accepted)
//   cpu_gnt, cpu_rd      CPU owns memory this cycle, read data
//   cpu_stall            cpu_req & ~cpu_gnt, for pipeline enables
//   dma_req/we/addr/wd   DMA request + payload
//   dma_gnt, dma_rd      DMA owns memory this cycle, read data
//   mem_we/a/wd, mem_rd  data memory side (combinational read)

module dmem_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [1:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic [31:0] dma_rd,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);
  localparam logic [CW-1:0] CLIM = CW'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN_CPU,
    OWN_DMA
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          last;     // 1: DMA was the last owner
  logic          cpu_xfer;
  logic          dma_xfer;
  logic          at_limit;
  logic          cpu_tie;
  logic          cpu_lim;
  logic          dma_lim;

  assign cpu_xfer  = cpu_gnt & cpu_req;
  assign dma_xfer  = dma_gnt & dma_req;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rd    = mem_rd;
  assign dma_rd    = mem_rd;

  // Switch on the edge that completes the BURST_MAX-th transfer;
  // a saturated count switches as soon as the other side asks.
  assign at_limit = (cnt >= CLIM);

`ifdef DMEM_ARB_CPU_PRIO_EN
  assign cpu_tie = 1'b1;
  assign cpu_lim = 1'b0;
`else
  assign cpu_tie = last;
  assign cpu_lim = at_limit;
`endif
  assign dma_lim = at_limit;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (cpu_req && dma_req)
          nxt = cpu_tie ? OWN_CPU : OWN_DMA;
        else if (cpu_req)
          nxt = OWN_CPU;
        else if (dma_req)
          nxt = OWN_DMA;
      end
      OWN_CPU: begin
        if (!cpu_req)
          nxt = dma_req ? OWN_DMA : IDLE;
        else if (dma_req && cpu_lim)
          nxt = OWN_DMA;
      end
      OWN_DMA: begin
        if (!dma_req)
          nxt = cpu_req ? OWN_CPU : IDLE;
        else if (cpu_req && dma_lim)
          nxt = OWN_CPU;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= 1'b1;
      cpu_gnt <= 1'b0;
      dma_gnt <= 1'b0;
    end else begin
      state   <= nxt;
      cpu_gnt <= (nxt == OWN_CPU);
      dma_gnt <= (nxt == OWN_DMA);
      if (nxt != state)
        cnt <= '0;
      else if ((cpu_xfer || dma_xfer) && cnt != CMAX)
        cnt <= cnt + CW'(1);
      if (nxt != state && nxt == OWN_CPU)
        last <= 1'b0;
      if (nxt != state && nxt == OWN_DMA)
        last <= 1'b1;
    end
  end

  // Owner's payload is always presented; only a live
  // request may write.
  always_comb begin
    mem_we = 2'b00;
    mem_a  = '0;
    mem_wd = '0;
    unique case (1'b1)
      cpu_gnt: begin
        mem_a  = cpu_addr;
        mem_wd = cpu_wd;
        mem_we = cpu_req ? cpu_we : 2'b00;
      end
      dma_gnt: begin
        mem_a  = dma_addr;
        mem_wd = dma_wd;
        mem_we = dma_req ? dma_we : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Expected transfers are queued by the stimulus and checked by a monitor.

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic [1:0]  cpu_we = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wd = '0;
  logic        cpu_gnt;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        dma_req = 1'b0;
  logic [1:0]  dma_we = '0;
  logic [31:0] dma_addr = '0;
  logic [31:0] dma_wd = '0;
  logic        dma_gnt;
  logic [31:0] dma_rd;
  logic [1:0]  mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  dmem_arbiter #(.BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_rd(cpu_rd),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wd(dma_wd),
    .dma_gnt(dma_gnt), .dma_rd(dma_rd),
    .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory: word array, sw/sh/sb writes, combinational read.
  logic [31:0] ram [0:1023];
  assign mem_rd = ram[mem_a[11:2]];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
  end

  always @(posedge clk) begin
    case (mem_we)
      2'b01: ram[mem_a[11:2]] <= mem_wd;
      2'b10:
        if (mem_a[1]) ram[mem_a[11:2]][31:16] <= mem_wd[15:0];
        else          ram[mem_a[11:2]][15:0]  <= mem_wd[15:0];
      2'b11:
        case (mem_a[1:0])
          2'b00: ram[mem_a[11:2]][7:0]   <= mem_wd[7:0];
          2'b01: ram[mem_a[11:2]][15:8]  <= mem_wd[7:0];
          2'b10: ram[mem_a[11:2]][23:16] <= mem_wd[7:0];
          default: ram[mem_a[11:2]][31:24] <= mem_wd[7:0];
        endcase
      default: ;
    endcase
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          p;
    logic [1:0]  we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(input bit p, input logic [1:0] we,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd);
    exp_t e;
    e.p = p; e.we = we; e.a = a; e.wd = wd; e.rd = rd;
    q.push_back(e);
  endfunction

  // Monitor: every transfer cycle must match the head of the queue.
  always @(negedge clk) begin
    bit cx;
    bit dx;
    exp_t e;
    cx = cpu_gnt && cpu_req;
    dx = dma_gnt && dma_req;
    if (cx || dx) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_xfer: got cpu=%0b dma=%0b expected none",
                 cx, dx);
      end else begin
        e = q.pop_front();
        chk("xfer_port", {31'b0, dx}, {31'b0, e.p});
        chk("xfer_we", {30'b0, mem_we}, {30'b0, e.we});
        chk("xfer_addr", mem_a, e.a);
        chk("xfer_wd", mem_wd, e.wd);
        if (e.we == 2'b00)
          chk("xfer_rd", dx ? dma_rd : cpu_rd, e.rd);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic r, input logic [1:0] we,
                       input logic [31:0] a, input logic [31:0] d);
    if (!p) begin
      cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wd = d;
    end else begin
      dma_req = r; dma_we = we; dma_addr = a; dma_wd = d;
    end
  endtask

  task automatic drop(input bit p);
    if (!p) cpu_req = 1'b0;
    else    dma_req = 1'b0;
  endtask

  // Wait (bounded) for the port's grant while its request is up.
  task automatic wait_gnt(input bit p, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (p ? dma_gnt : cpu_gnt) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: got no grant expected port %0d", p);
    end
  endtask

  // n back-to-back transfers; waits = stall cycles before the first.
  task automatic run(input bit p, input int n, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] d0,
                     output int waits);
    int w;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      drive(p, 1'b1, we, a0 + 32'(4 * i), d0 + 32'(i));
      wait_gnt(p, w);
      if (i == 0) waits = w;
      cycle();
    end
    drop(p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w1;
    int w2;
    int w3;
    int t0;

    // Reset with both requesting: nothing granted, memory idle.
    drive(0, 1'b1, 2'b00, 32'h40, 32'h0);
    drive(1, 1'b1, 2'b00, 32'h44, 32'h0);
    push(0, 2'b00, 32'h40, 32'h0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
      chk("rst_dma_gnt", {31'b0, dma_gnt}, 32'h0);
      chk("rst_mem_we", {30'b0, mem_we}, 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
    end
    cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'b0, cpu_stall}, 32'h1);
    chk("idle_gnt", {31'b0, cpu_gnt}, 32'h0);
    @(negedge clk);
    chk("tie_cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
    chk("tie_dma_gnt", {31'b0, dma_gnt}, 32'h0);
    chk("tie_stall", {31'b0, cpu_stall}, 32'h0);
    cycle();
    drop(1);
    drive(0, 1'b0, 2'b01, 32'h40, 32'h1234);
    @(negedge clk);
    chk("reqlow_gnt", {31'b0, cpu_gnt}, 32'h1);
    chk("reqlow_we", {30'b0, mem_we}, 32'h0);
    cycle();

    // Single CPU store, then load back.
    push(0, 2'b01, 32'h10, 32'hDEADBEEF, 32'h0);
    run(0, 1, 2'b01, 32'h10, 32'hDEADBEEF, w1);
    chk("sw_stall", 32'(w1), 32'd1);
    cycle();
    push(0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF);
    run(0, 1, 2'b00, 32'h10, 32'h0, w1);
    chk("lw_stall", 32'(w1), 32'd1);
    cycle();

    // DMA word, byte and half stores.
    push(1, 2'b01, 32'h10, 32'h11223344, 32'h0);
    run(1, 1, 2'b01, 32'h10, 32'h11223344, w1);
    chk("dma_stall", 32'(w1), 32'd1);
    cycle();
    push(1, 2'b11, 32'h13, 32'hAB, 32'h0);
    run(1, 1, 2'b11, 32'h13, 32'hAB, w1);
    cycle();
    push(0, 2'b00, 32'h10, 32'h0, 32'hAB223344);
    run(0, 1, 2'b00, 32'h10, 32'h0, w1);
    cycle();
    push(1, 2'b10, 32'h12, 32'h5566, 32'h0);
    run(1, 1, 2'b10, 32'h12, 32'h5566, w1);
    cycle();
    push(1, 2'b00, 32'h10, 32'h0, 32'h55663344);
    run(1, 1, 2'b00, 32'h10, 32'h0, w1);
    cycle();

    // Contention: both stream 8 stores from IDLE (last = DMA).
`ifdef DMEM_ARB_CPU_PRIO_EN
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++)
        push(p[0], 2'b01,
             (p == 1 ? 32'h200 : 32'h100) + 32'(4 * i),
             (p == 1 ? 32'hD0000000 : 32'hC0000000) + 32'(i), 32'h0);
`else
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 4; j++)
        push(b[0], 2'b01,
             (b[0] ? 32'h200 : 32'h100) + 32'(4 * ((b / 2) * 4 + j)),
             (b[0] ? 32'hD0000000 : 32'hC0000000) + 32'((b / 2) * 4 + j),
             32'h0);
`endif
    t0 = cyc;
    fork
      run(0, 8, 2'b01, 32'h100, 32'hC0000000, w1);
      run(1, 8, 2'b01, 32'h200, 32'hD0000000, w2);
    join
`ifdef DMEM_ARB_CPU_PRIO_EN
    chk("burst_cycles", 32'(cyc - t0), 32'd18);
`else
    chk("burst_cycles", 32'(cyc - t0), 32'd17);
`endif
    cycle();
    push(0, 2'b00, 32'h10C, 32'h0, 32'hC0000003);
    run(0, 1, 2'b00, 32'h10C, 32'h0, w1);
    cycle();

    // Owner drop after 2 transfers while DMA waits.
    push(0, 2'b01, 32'h400, 32'hA0, 32'h0);
    push(0, 2'b01, 32'h404, 32'hA1, 32'h0);
    for (int i = 0; i < 4; i++)
      push(1, 2'b01, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 32'h0);
    push(0, 2'b01, 32'h480, 32'hAA, 32'h0);
    for (int i = 4; i < 6; i++)
      push(1, 2'b01, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 32'h0);
    fork
      begin
        run(0, 2, 2'b01, 32'h400, 32'hA0, w1);
        @(negedge clk);
        chk("drop_cpu_gnt", {31'b0, cpu_gnt}, 32'h1);
        chk("drop_dma_gnt", {31'b0, dma_gnt}, 32'h0);
        chk("drop_mem_we", {30'b0, mem_we}, 32'h0);
        cycle();
        run(0, 1, 2'b01, 32'h480, 32'hAA, w3);
      end
      begin
        cycle();
        run(1, 6, 2'b01, 32'h500, 32'hB0, w2);
      end
    join
    chk("drop_dma_wait", 32'(w2), 32'd3);
    chk("drop_cpu_wait", 32'(w3), 32'd4);
    cycle();

    // Reset in the middle of a DMA burst.
    repeat (3) push(1, 2'b00, 32'h10, 32'h0, 32'h55663344);
    drive(1, 1'b1, 2'b00, 32'h10, 32'h0);
    wait_gnt(1, w1);
    cycle();
    @(negedge clk);
    chk("mid_dma_gnt", {31'b0, dma_gnt}, 32'h1);
    cycle();
    reset = 1'b1;
    drive(0, 1'b1, 2'b00, 32'h10, 32'h0);
    push(0, 2'b00, 32'h10, 32'h0, 32'h55663344);
    cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_cpu", {31'b0, cpu_gnt}, 32'h0);
    chk("mid_rst_dma", {31'b0, dma_gnt}, 32'h0);
    chk("mid_rst_we", {30'b0, mem_we}, 32'h0);
    cycle();
    @(negedge clk);
    chk("mid_tie_cpu", {31'b0, cpu_gnt}, 32'h1);
    chk("mid_tie_dma", {31'b0, dma_gnt}, 32'h0);
    cycle();
    drop(0);
    push(1, 2'b00, 32'h10, 32'h0, 32'h55663344);
    wait_gnt(1, w1);
    cycle();
    drop(1);
    repeat (3) cycle();

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
